csr_port_arbiter: RTL and testbench
===================================

Name: csr_port_arbiter

Overview:
- Owns the single read/write port of the CSR register file.
- Shares the port between two requesters:
  - the trap sequencer (mepc/mcause writes, mtvec/mepc reads), which always has priority;
  - the pipeline Zicsr unit (CSRRW/RS/RC and their immediate forms), which it sequences as a READ -> WRITE read-modify-write and stalls until done.
- Sits between the decode/execute stage, the trap sequencer and the CSR file.

Parameters:
- XLEN, 32, data width of CSR values.
- RO_CHECK, 1, when 1 a write attempt to addr[11:10]==2'b11 is flagged illegal and suppressed.

Ports:
- clk  in  1  core clock.
- reset_n  in  1  asynchronous active-low reset.
- trap_active  in  1  trap sequencer owns the port this cycle (~trap_done, or MRET in progress).
- trap_csr_we  in  1  trap sequencer write enable.
- trap_csr_addr  in  12  trap sequencer CSR address.
- trap_csr_wdata  in  XLEN  trap sequencer write data.
- trap_csr_rdata  out  XLEN  CSR file read data returned to the trap sequencer (pass-through).
- csr_req  in  1  pipeline CSR instruction pending; held until csr_ack or flush.
- csr_funct3  in  3  instruction funct3.
- csr_addr  in  12  CSR address.
- csr_src  in  XLEN  rs1 value, or zimm zero-extended for the I forms.
- csr_rs1_idx  in  5  rs1 field (the zimm field for I forms).
- csr_ack  out  1  one-cycle completion pulse.
- csr_illegal  out  1  one-cycle pulse: illegal funct3 or RO write; coincides with csr_ack.
- csr_old_value  out  XLEN  pre-write CSR value for rd; valid while csr_ack=1 and held until the next capture.
- pipe_stall  out  1  stall request to the pipeline.
- csr_file_we  out  1  write enable to the CSR file.
- csr_file_addr  out  12  address to the CSR file.
- csr_file_wdata  out  XLEN  write data to the CSR file.
- csr_file_rdata  in  XLEN  combinational read data from the CSR file.

Behaviour:
- Reset (asynchronous, reset_n=0):
  - state=IDLE; csr_old_value=0, csr_ack=0, csr_illegal=0.
  - pipe_stall=0, csr_file_we=0, csr_file_addr=0, csr_file_wdata=0.
- Reset mid-operation aborts the access with no write.
- States: IDLE, READ, WRITE, DONE (encoding from the shared package).
- Port mux (combinational):
  - If trap_active=1: file_we/addr/wdata = trap_csr_we/trap_csr_addr/trap_csr_wdata.
  - Else READ drives addr=csr_addr, we=0.
  - Else WRITE drives addr=csr_addr, wdata=new_value, we=~suppress.
  - Otherwise all zero.
  - trap_csr_rdata = csr_file_rdata at all times.
- IDLE:
  - csr_req=1 and trap_active=0 -> READ.
  - If csr_funct3 is 000 or 100 -> DONE with illegal set; the file is not accessed.
- READ:
  - Capture csr_file_rdata into csr_old_value.
  - Then -> WRITE, or -> DONE if suppress=1.
  - If RO_CHECK=1, addr[11:10]==2'b11 and the op writes -> DONE with illegal set; no write.
- WRITE: write issued this cycle -> DONE.
- DONE:
  - csr_ack=1 (and csr_illegal if set) for exactly 1 cycle -> IDLE.
  - No new request is accepted in the DONE cycle.
- new_value, computed from old = csr_old_value:
  - RW/RWI: src.
  - RS/RSI: old | src.
  - RC/RCI: old & ~src.
- suppress = 1 for RS/RC/RSI/RCI when csr_rs1_idx==0. RW always writes.
- Latency, trap-free: request seen in cycle 0; READ in cycle 1, WRITE in cycle 2, ack in cycle 3. A suppressed access acks in cycle 2.
- Preemption: trap_active=1 while in READ or WRITE:
  - Abort to IDLE with no pipeline write and no ack.
  - The request restarts from READ in the first cycle after trap_active falls, if csr_req is still high.
- trap_active=1 in IDLE holds the FSM in IDLE.
- trap_active=1 in DONE does not cancel the ack; the write has already completed.
- csr_req dropped (flush) in READ/WRITE -> IDLE, no write. Dropped in DONE -> ack still pulses; the pipeline ignores it.
- pipe_stall = csr_req & (state != DONE).

Decomposition:
- Shared package csr_pkg holds:
  - funct3 codes (CSRRW=001, CSRRS=010, CSRRC=011, CSRRWI=101, CSRRSI=110, CSRRCI=111);
  - CSR addresses (MTVEC 12'h305, MSCRATCH 12'h340, MEPC 12'h341, MCAUSE 12'h342);
  - the arbiter state encoding.
- Sub-module csr_rmw_alu (combinational): funct3, old, src, rs1_idx -> new_value, suppress, writes, illegal_op.

Test Plan:
- CSRRW 0x340, old 0x11, src 0xA5, rs1_idx=5 -> cycle 2 we=1 wdata=0xA5; cycle 3 ack=1, old_value=0x11; pipe_stall high for cycles 0-2.
- CSRRC 0x340, old 0xFF, src 0x0F, rs1_idx=3 -> write 0xF0, ack cycle 3. CSRRS with rs1_idx=0 -> no we, ack cycle 2, old_value=0xF0.
- trap_active rises during WRITE while the trap writes mepc=0x100 -> file sees addr 0x341, wdata 0x100, no pipeline write. After trap_active falls the request re-reads and acks 3 cycles later.
- CSRRW to 0xC00 -> csr_illegal=1 and csr_ack=1 in cycle 2, csr_file_we never 1. CSRRS x0 to 0xC00 -> legal read, no illegal.
- funct3=100 -> illegal+ack in cycle 1, file untouched.
- reset_n=0 during READ -> all outputs 0 immediately. Re-request after release -> normal 3-cycle ack.

Source files
------------

// File: rtl/csr_port_arbiter_pkg.sv
// Shared definitions for the CSR port arbiter slice.
//   - Zicsr funct3 encodings
//   - machine-mode CSR addresses used by the trap sequencer
//   - arbiter state encoding
package csr_pkg;

  localparam logic [2:0] F3_CSRRW  = 3'b001;
  localparam logic [2:0] F3_CSRRS  = 3'b010;
  localparam logic [2:0] F3_CSRRC  = 3'b011;
  localparam logic [2:0] F3_CSRRWI = 3'b101;
  localparam logic [2:0] F3_CSRRSI = 3'b110;
  localparam logic [2:0] F3_CSRRCI = 3'b111;

  localparam logic [11:0] CSR_MTVEC    = 12'h305;
  localparam logic [11:0] CSR_MSCRATCH = 12'h340;
  localparam logic [11:0] CSR_MEPC     = 12'h341;
  localparam logic [11:0] CSR_MCAUSE   = 12'h342;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_READ  = 2'd1,
    ARB_WRITE = 2'd2,
    ARB_DONE  = 2'd3
  } arb_state_e;

endpackage

// File: rtl/csr_port_arbiter_rmw_alu.sv
// Combinational read-modify-write datapath for Zicsr instructions.
// Ports:
//   funct3     - instruction funct3
//   old_value  - CSR value captured in the read phase
//   src        - rs1 value or zero-extended zimm
//   rs1_idx    - rs1 / zimm field
//   new_value  - value to write back
//   suppress   - set/clear with x0/zimm==0: no write
//   writes     - the instruction performs a write
//   illegal_op - funct3 is not a Zicsr encoding
module csr_rmw_alu
  import csr_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] old_value,
  input  logic [XLEN-1:0] src,
  input  logic [4:0]      rs1_idx,
  output logic [XLEN-1:0] new_value,
  output logic            suppress,
  output logic            writes,
  output logic            illegal_op
);

  always_comb begin
    new_value  = '0;
    illegal_op = 1'b0;
    case (funct3)
      F3_CSRRW, F3_CSRRWI: new_value = src;
      F3_CSRRS, F3_CSRRSI: new_value = old_value | src;
      F3_CSRRC, F3_CSRRCI: new_value = old_value & ~src;
      default:             illegal_op = 1'b1;
    endcase
    // funct3[1] selects the set/clear family; RW forms always write.
    suppress = !illegal_op && funct3[1] && (rs1_idx == '0);
    writes   = !illegal_op && !suppress;
  end

endmodule

// File: rtl/csr_port_arbiter.sv
// Arbiter for the single read/write port of the CSR register file.
// The trap sequencer always wins the port; the pipeline Zicsr unit is
// sequenced as READ -> WRITE and stalled until its one-cycle ack.
// Ports:
//   clk, reset_n                 - clock, asynchronous active-low reset
//   trap_active/we/addr/wdata    - trap sequencer port request
//   trap_csr_rdata               - CSR file read data to the trap sequencer
//   csr_req/funct3/addr/src/rs1  - pipeline Zicsr request
//   csr_ack, csr_illegal         - completion / illegal pulse
//   csr_old_value                - pre-write CSR value for rd
//   pipe_stall                   - stall request to the pipeline
//   csr_file_we/addr/wdata/rdata - CSR file port
module csr_port_arbiter
  import csr_pkg::*;
#(
  parameter int unsigned XLEN     = 32,
  parameter bit          RO_CHECK = 1'b1
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            trap_active,
  input  logic            trap_csr_we,
  input  logic [11:0]     trap_csr_addr,
  input  logic [XLEN-1:0] trap_csr_wdata,
  output logic [XLEN-1:0] trap_csr_rdata,
  input  logic            csr_req,
  input  logic [2:0]      csr_funct3,
  input  logic [11:0]     csr_addr,
  input  logic [XLEN-1:0] csr_src,
  input  logic [4:0]      csr_rs1_idx,
  output logic            csr_ack,
  output logic            csr_illegal,
  output logic [XLEN-1:0] csr_old_value,
  output logic            pipe_stall,
  output logic            csr_file_we,
  output logic [11:0]     csr_file_addr,
  output logic [XLEN-1:0] csr_file_wdata,
  input  logic [XLEN-1:0] csr_file_rdata
);

  arb_state_e      state;
  logic [XLEN-1:0] new_value;
  logic            suppress;
  logic            writes;
  logic            illegal_op;
  logic            ro_violation;

  csr_rmw_alu #(.XLEN(XLEN)) u_rmw_alu (
    .funct3     (csr_funct3),
    .old_value  (csr_old_value),
    .src        (csr_src),
    .rs1_idx    (csr_rs1_idx),
    .new_value  (new_value),
    .suppress   (suppress),
    .writes     (writes),
    .illegal_op (illegal_op)
  );

  // Read-only CSR space is addr[11:10]==2'b11; only actual writes trap.
  assign ro_violation = RO_CHECK && (csr_addr[11:10] == 2'b11) && writes;

  // csr_ack/csr_illegal are registered on entry to DONE so they are high
  // exactly for the DONE cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= ARB_IDLE;
      csr_ack       <= 1'b0;
      csr_illegal   <= 1'b0;
      csr_old_value <= '0;
    end else begin
      csr_ack     <= 1'b0;
      csr_illegal <= 1'b0;
      case (state)
        ARB_IDLE: begin
          if (csr_req && !trap_active) begin
            if (illegal_op) begin
              state       <= ARB_DONE;
              csr_ack     <= 1'b1;
              csr_illegal <= 1'b1;
            end else begin
              state <= ARB_READ;
            end
          end
        end
        ARB_READ: begin
          if (trap_active || !csr_req) begin
            state <= ARB_IDLE;
          end else begin
            csr_old_value <= csr_file_rdata;
            if (ro_violation) begin
              state       <= ARB_DONE;
              csr_ack     <= 1'b1;
              csr_illegal <= 1'b1;
            end else if (suppress) begin
              state   <= ARB_DONE;
              csr_ack <= 1'b1;
            end else begin
              state <= ARB_WRITE;
            end
          end
        end
        ARB_WRITE: begin
          if (trap_active || !csr_req) begin
            state <= ARB_IDLE;
          end else begin
            state   <= ARB_DONE;
            csr_ack <= 1'b1;
          end
        end
        default: state <= ARB_IDLE;
      endcase
    end
  end

  // Port mux. Held at zero while reset is asserted so the file sees no
  // access even if a requester is still driving.
  always_comb begin
    csr_file_we    = 1'b0;
    csr_file_addr  = '0;
    csr_file_wdata = '0;
    if (reset_n) begin
      if (trap_active) begin
        csr_file_we    = trap_csr_we;
        csr_file_addr  = trap_csr_addr;
        csr_file_wdata = trap_csr_wdata;
      end else if (state == ARB_READ) begin
        csr_file_addr = csr_addr;
      end else if (state == ARB_WRITE) begin
        csr_file_addr  = csr_addr;
        csr_file_wdata = new_value;
        // A flushed request must not commit its write.
        csr_file_we    = csr_req && !suppress;
      end
    end
  end

  assign trap_csr_rdata = csr_file_rdata;
  assign pipe_stall     = reset_n && csr_req && (state != ARB_DONE);

endmodule

// File: tb/tb_csr_port_arbiter.sv
module tb_csr_port_arbiter;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n;
  logic        trap_active, trap_csr_we;
  logic [11:0] trap_csr_addr;
  logic [31:0] trap_csr_wdata, trap_csr_rdata;
  logic        csr_req;
  logic [2:0]  csr_funct3;
  logic [11:0] csr_addr;
  logic [31:0] csr_src;
  logic [4:0]  csr_rs1_idx;
  logic        csr_ack, csr_illegal;
  logic [31:0] csr_old_value;
  logic        pipe_stall, csr_file_we;
  logic [11:0] csr_file_addr;
  logic [31:0] csr_file_wdata, csr_file_rdata;

  logic [31:0] dut_mem [0:4095];
  logic [31:0] ref_mem [0:4095];
  assign csr_file_rdata = dut_mem[csr_file_addr];

  csr_port_arbiter #(.XLEN(32), .RO_CHECK(1'b1)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .trap_active    (trap_active),
    .trap_csr_we    (trap_csr_we),
    .trap_csr_addr  (trap_csr_addr),
    .trap_csr_wdata (trap_csr_wdata),
    .trap_csr_rdata (trap_csr_rdata),
    .csr_req        (csr_req),
    .csr_funct3     (csr_funct3),
    .csr_addr       (csr_addr),
    .csr_src        (csr_src),
    .csr_rs1_idx    (csr_rs1_idx),
    .csr_ack        (csr_ack),
    .csr_illegal    (csr_illegal),
    .csr_old_value  (csr_old_value),
    .pipe_stall     (pipe_stall),
    .csr_file_we    (csr_file_we),
    .csr_file_addr  (csr_file_addr),
    .csr_file_wdata (csr_file_wdata),
    .csr_file_rdata (csr_file_rdata)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h expected=0x%08h t=%0t", name, act, exp, $time);
    end
  endtask

  // Transaction-level reference: an accepted request has a fixed timeline
  // measured in cycles since acceptance (ack at 1, 2 or 3 depending on
  // outcome; read at 1, write at 2), cancelled by trap or flush before ack.
  bit          m_act;
  int          m_age, m_ack_age;
  bit          m_ill;
  logic [31:0] m_old;

  bit          e_done, e_abort, e_accept, e_cap, e_we, ck_addr, ck_wdata;
  logic [11:0] e_addr;
  logic [31:0] e_wdata;
  bit          p_we;
  logic [11:0] p_addr;
  logic [31:0] p_wdata;
  bit          last_done;

  function automatic logic [31:0] rmw(input logic [2:0] f3, input logic [31:0] old, input logic [31:0] src);
    case (f3[1:0])
      2'b01:   return src;
      2'b10:   return old | src;
      default: return old & ~src;
    endcase
  endfunction

  task automatic sample();
    @(negedge clk);
    e_done = 0; e_abort = 0; e_accept = 0; e_cap = 0; e_we = 0;
    e_addr = '0; e_wdata = '0; ck_addr = 1; ck_wdata = 1;
    if (!reset_n) begin
      chk("rst_ack", csr_ack, 0);
      chk("rst_illegal", csr_illegal, 0);
      chk("rst_old", csr_old_value, 0);
      chk("rst_stall", pipe_stall, 0);
      chk("rst_we", csr_file_we, 0);
      chk("rst_addr", csr_file_addr, 0);
      chk("rst_wdata", csr_file_wdata, 0);
    end else begin
      e_done = m_act && (m_age == m_ack_age);
      if (trap_active) begin
        e_we = trap_csr_we; e_addr = trap_csr_addr; e_wdata = trap_csr_wdata;
        if (m_act && !e_done) e_abort = 1;
      end else if (m_act && !e_done) begin
        if (!csr_req) begin
          e_abort = 1; ck_addr = 0; ck_wdata = 0;
        end else if (m_age == 1) begin
          e_cap = 1; e_addr = csr_addr; ck_wdata = 0;
        end else begin
          e_we = 1; e_addr = csr_addr; e_wdata = rmw(csr_funct3, m_old, csr_src);
        end
      end
      if (!m_act && csr_req && !trap_active) e_accept = 1;
      chk("ack", csr_ack, e_done);
      chk("illegal", csr_illegal, e_done && m_ill);
      chk("stall", pipe_stall, csr_req && !e_done);
      chk("file_we", csr_file_we, e_we);
      if (ck_addr) chk("file_addr", csr_file_addr, e_addr);
      if (ck_wdata) chk("file_wdata", csr_file_wdata, e_wdata);
      if (e_done) chk("old_value", csr_old_value, m_old);
      chk("trap_rdata", trap_csr_rdata, dut_mem[csr_file_addr]);
    end
    p_we = csr_file_we; p_addr = csr_file_addr; p_wdata = csr_file_wdata;
  endtask

  task automatic advance();
    @(posedge clk);
    if (p_we) dut_mem[p_addr] = p_wdata;
    if (e_we) ref_mem[e_addr] = e_wdata;
    last_done = e_done;
    if (!reset_n) begin
      m_act = 0; m_old = '0;
    end else if (e_done || e_abort) begin
      m_act = 0;
    end else if (m_act) begin
      if (e_cap) m_old = ref_mem[csr_addr];
      m_age++;
    end else if (e_accept) begin
      m_act = 1; m_age = 1; m_ill = 0;
      if (csr_funct3[1:0] == 2'b00) begin
        m_ack_age = 1; m_ill = 1;
      end else if (csr_funct3[1] && csr_rs1_idx == 5'd0) begin
        m_ack_age = 2;
      end else if (csr_addr[11:10] == 2'b11) begin
        m_ack_age = 2; m_ill = 1;
      end else begin
        m_ack_age = 3;
      end
    end
    #1;
  endtask

  task automatic setmem(input logic [11:0] a, input logic [31:0] v);
    dut_mem[a] = v;
    ref_mem[a] = v;
  endtask

  task automatic req(input logic [2:0] f3, input logic [11:0] a, input logic [31:0] s, input logic [4:0] r);
    csr_req = 1; csr_funct3 = f3; csr_addr = a; csr_src = s; csr_rs1_idx = r;
  endtask

  logic [11:0] aset [8];
  int trap_left;

  initial begin
    aset[0] = 12'h305; aset[1] = 12'h340; aset[2] = 12'h341; aset[3] = 12'h342;
    aset[4] = 12'hC00; aset[5] = 12'hC01; aset[6] = 12'hBFF; aset[7] = 12'h7C0;
    for (int i = 0; i < 4096; i++) begin
      dut_mem[i] = '0;
      ref_mem[i] = '0;
    end
    m_act = 0; m_age = 0; m_ack_age = 0; m_ill = 0; m_old = '0; last_done = 0;
    reset_n = 0; trap_active = 0; trap_csr_we = 0; trap_csr_addr = '0; trap_csr_wdata = '0;
    csr_req = 0; csr_funct3 = '0; csr_addr = '0; csr_src = '0; csr_rs1_idx = '0;
    trap_left = 0;
    sample(); advance();
    sample(); advance();
    reset_n = 1;
    sample(); advance();

    // CSRRW 0x340: write in cycle 2, ack in cycle 3
    setmem(12'h340, 32'h11);
    req(3'b001, 12'h340, 32'hA5, 5'd5);
    sample(); chk("t1_stall0", pipe_stall, 1); advance();
    sample(); chk("t1_stall1", pipe_stall, 1); chk("t1_rd_we", csr_file_we, 0); advance();
    sample(); chk("t1_we", csr_file_we, 1); chk("t1_wdata", csr_file_wdata, 32'hA5);
    chk("t1_stall2", pipe_stall, 1); advance();
    sample(); chk("t1_ack", csr_ack, 1); chk("t1_old", csr_old_value, 32'h11);
    chk("t1_stall3", pipe_stall, 0); advance();
    csr_req = 0; sample(); advance();

    // CSRRC then CSRRS x0 (suppressed)
    setmem(12'h340, 32'hFF);
    req(3'b011, 12'h340, 32'h0F, 5'd3);
    sample(); advance();
    sample(); advance();
    sample(); chk("t2_we", csr_file_we, 1); chk("t2_wdata", csr_file_wdata, 32'hF0); advance();
    sample(); chk("t2_ack", csr_ack, 1); chk("t2_old", csr_old_value, 32'hFF); advance();
    req(3'b010, 12'h340, 32'h0, 5'd0);
    sample(); advance();
    sample(); chk("t2s_we", csr_file_we, 0); advance();
    sample(); chk("t2s_ack", csr_ack, 1); chk("t2s_old", csr_old_value, 32'hF0);
    chk("t2s_we2", csr_file_we, 0); advance();
    csr_req = 0; sample(); advance();

    // Trap preempts WRITE with an mepc write
    req(3'b001, 12'h340, 32'h55, 5'd1);
    sample(); advance();
    sample(); advance();
    trap_active = 1; trap_csr_we = 1; trap_csr_addr = 12'h341; trap_csr_wdata = 32'h100;
    sample(); chk("t3_we", csr_file_we, 1); chk("t3_addr", csr_file_addr, 12'h341);
    chk("t3_wdata", csr_file_wdata, 32'h100); chk("t3_noack", csr_ack, 0); advance();
    trap_active = 0; trap_csr_we = 0;
    sample(); chk("t3_noack2", csr_ack, 0); advance();
    sample(); chk("t3_rd_we", csr_file_we, 0); advance();
    sample(); chk("t3_re_we", csr_file_we, 1); chk("t3_re_wdata", csr_file_wdata, 32'h55); advance();
    sample(); chk("t3_ack", csr_ack, 1); chk("t3_old", csr_old_value, 32'hF0); advance();
    chk("t3_mepc", dut_mem[12'h341], 32'h100);
    csr_req = 0; sample(); advance();

    // Read-only space: write is illegal, x0 read is legal
    req(3'b001, 12'hC00, 32'h1, 5'd2);
    sample(); advance();
    sample(); advance();
    sample(); chk("t4_ack", csr_ack, 1); chk("t4_ill", csr_illegal, 1); advance();
    req(3'b010, 12'hC00, 32'h0, 5'd0);
    sample(); advance();
    sample(); advance();
    sample(); chk("t4r_ack", csr_ack, 1); chk("t4r_ill", csr_illegal, 0); advance();
    csr_req = 0; sample(); advance();

    // Illegal funct3 acks in cycle 1
    req(3'b100, 12'h340, 32'h1, 5'd1);
    sample(); advance();
    sample(); chk("t5_ack", csr_ack, 1); chk("t5_ill", csr_illegal, 1); chk("t5_we", csr_file_we, 0); advance();
    csr_req = 0; sample(); advance();

    // Reset during READ, then re-request
    req(3'b001, 12'h342, 32'h77, 5'd4);
    sample(); advance();
    reset_n = 0;
    sample(); chk("t6_stall", pipe_stall, 0); chk("t6_addr", csr_file_addr, 0); advance();
    reset_n = 1;
    sample(); advance();
    sample(); advance();
    sample(); chk("t6_we", csr_file_we, 1); chk("t6_wdata", csr_file_wdata, 32'h77); advance();
    sample(); chk("t6_ack", csr_ack, 1); advance();
    csr_req = 0; sample(); advance();

    // Randomized traffic
    for (int cyc = 0; cyc < 4000; cyc++) begin
      reset_n = ($urandom_range(0, 149) != 0);
      if (trap_left > 0) begin
        trap_active = 1; trap_left--;
      end else if ($urandom_range(0, 9) == 0) begin
        trap_active = 1; trap_left = $urandom_range(0, 3);
      end else begin
        trap_active = 0;
      end
      trap_csr_we = 1'($urandom_range(0, 1));
      trap_csr_addr = aset[$urandom_range(0, 7)];
      trap_csr_wdata = $urandom;
      if (!csr_req || last_done) begin
        if ($urandom_range(0, 9) < 5) begin
          logic [4:0] r;
          logic [2:0] f;
          r = ($urandom_range(0, 2) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
          f = 3'($urandom_range(0, 7));
          req(f, aset[$urandom_range(0, 7)], f[2] ? {27'd0, r} : $urandom, r);
        end else begin
          csr_req = 0;
        end
      end else if ($urandom_range(0, 39) == 0) begin
        csr_req = 0;
      end
      sample();
      advance();
    end

    reset_n = 1; trap_active = 0; csr_req = 0;
    sample(); advance();
    for (int i = 0; i < 8; i++) chk("mem_final", dut_mem[aset[i]], ref_mem[aset[i]]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
